// File: rtl/tank_pkg.sv
// tank_pkg: shared fire-control types and constants.
//   fire_state_t     - fire controller FSM states
//   FIRE_KEY_DEFAULT - HID usage code of the fire key (space bar)
//   SLOT_IDX_W       - width of a bullet slot index
package tank_pkg;
  typedef enum logic [1:0] {IDLE, ARM, COOLDOWN, DEAD} fire_state_t;
  localparam logic [7:0] FIRE_KEY_DEFAULT = 8'h2C;
  localparam int SLOT_IDX_W = 3;
endpackage

// File: rtl/first_free_slot.sv
// first_free_slot: combinational priority encoder for the lowest inactive bullet slot.
//   busy  - per-slot active flags
//   idx   - lowest index whose busy bit is clear
//   valid - at least one slot is free
module first_free_slot import tank_pkg::*; #(
  parameter int N = 5
) (
  input  logic [N-1:0]          busy,
  output logic [SLOT_IDX_W-1:0] idx,
  output logic                  valid
);
  always_comb begin
    idx = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (!busy[i]) begin
        idx = SLOT_IDX_W'(i);
        valid = 1'b1;
      end
  end
endmodule

// File: rtl/bullet_fire_ctrl.sv
// bullet_fire_ctrl: per-tank fire controller that hands shots to free bullet slots.
//   frame_clk        - one rising edge per video frame
//   Reset            - asynchronous, active-high
//   keycode          - four HID key bytes, any of them may hold FIRE_KEY
//   is_bullet_active - per-slot active flag from the bullet instances
//   hit              - tank destroyed
//   create           - one-hot create request to the chosen slot
//   armed_slot       - slot currently or last requested
//   ammo_left        - registered count of inactive slots
//   shot_count       - acknowledged shots, wrapping
//   timeout_err      - sticky, a slot failed to acknowledge in time
//   tank_alive       - low after hit until Reset
// Build option: BULLET_AUTOFIRE_EN makes a held key fire repeatedly.
module bullet_fire_ctrl import tank_pkg::*; #(
  parameter int         N_BULLETS       = 5,
  parameter logic [7:0] FIRE_KEY        = FIRE_KEY_DEFAULT,
  parameter int         COOLDOWN_FRAMES = 10,
  parameter int         ARM_TIMEOUT     = 4
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic [31:0]           keycode,
  input  logic [N_BULLETS-1:0]  is_bullet_active,
  input  logic                  hit,
  output logic [N_BULLETS-1:0]  create,
  output logic [SLOT_IDX_W-1:0] armed_slot,
  output logic [3:0]            ammo_left,
  output logic [15:0]           shot_count,
  output logic                  timeout_err,
  output logic                  tank_alive
);
  localparam int AW = $clog2(ARM_TIMEOUT + 1);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  fire_state_t state, state_n;
  logic [AW-1:0] arm_timer, timer_n;
  logic [CW-1:0] cd, cd_n;
  logic [N_BULLETS-1:0] create_n;
  logic [SLOT_IDX_W-1:0] slot_n, free_idx;
  logic [15:0] shots_n;
  logic to_n, alive_n, fire_req, fire_prev, trig, free_ok, ack;
  first_free_slot #(.N(N_BULLETS)) u_sel (
    .busy(is_bullet_active),
    .idx(free_idx),
    .valid(free_ok)
  );
  assign fire_req = keycode[7:0] == FIRE_KEY || keycode[15:8] == FIRE_KEY ||
                    keycode[23:16] == FIRE_KEY || keycode[31:24] == FIRE_KEY;
`ifdef BULLET_AUTOFIRE_EN
  assign trig = fire_req;
`else
  assign trig = fire_req & ~fire_prev;
`endif
  assign ack = is_bullet_active[armed_slot];
  always_comb begin
    state_n = state;
    create_n = create;
    slot_n = armed_slot;
    timer_n = arm_timer;
    cd_n = cd;
    shots_n = shot_count;
    to_n = timeout_err;
    alive_n = tank_alive;
    if (hit) begin
      state_n = DEAD;
      create_n = '0;
      alive_n = 1'b0;
    end else begin
      case (state)
        IDLE:
          if (trig && free_ok) begin
            state_n = ARM;
            create_n = N_BULLETS'(1) << free_idx;
            slot_n = free_idx;
            timer_n = '0;
          end
        ARM:
          if (ack || arm_timer == AW'(ARM_TIMEOUT - 1)) begin
            state_n = COOLDOWN;
            create_n = '0;
            cd_n = CW'(COOLDOWN_FRAMES - 1);
            shots_n = ack ? shot_count + 16'd1 : shot_count;
            to_n = ack ? timeout_err : 1'b1;
          end else
            timer_n = arm_timer + AW'(1);
        COOLDOWN:
          if (cd == '0)
            state_n = IDLE;
          else
            cd_n = cd - CW'(1);
        default: ;
      endcase
    end
  end
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state <= IDLE;
      create <= '0;
      armed_slot <= '0;
      arm_timer <= '0;
      cd <= '0;
      shot_count <= '0;
      timeout_err <= 1'b0;
      tank_alive <= 1'b1;
      fire_prev <= 1'b0;
      ammo_left <= 4'(N_BULLETS);
    end else begin
      state <= state_n;
      create <= create_n;
      armed_slot <= slot_n;
      arm_timer <= timer_n;
      cd <= cd_n;
      shot_count <= shots_n;
      timeout_err <= to_n;
      tank_alive <= alive_n;
      fire_prev <= fire_req;
      ammo_left <= 4'($countones(~is_bullet_active));
    end
endmodule
